// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the RV32 pipeline hazard controller.
//   fwd_sel_t   : encoding of the Execute-stage forwarding mux3 selects
//   mdu_state_t : state of the multiply/divide stall sequencer
//   fwd_select  : picks the forwarding source for one Execute operand
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   // The Memory stage holds the younger result, so it wins over Writeback.
   // x0 is hardwired to zero and is never forwarded.
   function automatic fwd_sel_t fwd_select(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic [4:0] rd_w,
      input logic       we_m,
      input logic       we_w
   );
      fwd_sel_t sel;
      sel = FWD_RF;
      if (rs != 5'd0 && rs == rd_m && we_m) begin
         sel = FWD_MEM;
      end else if (rs != 5'd0 && rs == rd_w && we_w) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_fsm.sv
// -----------------------------------------------------------------------------
// mdu_stall_fsm
// Sequences a multi-cycle MDU op sitting in Execute. The op stalls the front
// of the pipe for MDU_LATENCY-1 cycles, then gets one release cycle in which
// it leaves Execute.
// Ports:
//   clk       : core clock
//   reset     : synchronous, active-low reset
//   mdu_op_e  : valid MDU instruction in Execute
//   mdu_stall : hold F/D/E and bubble M this cycle
//   mdu_busy  : sequencer is in BUSY
// -----------------------------------------------------------------------------
module mdu_stall_fsm
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic mdu_op_e,
   output logic mdu_stall,
   output logic mdu_busy
);

   localparam int CNT_W = $clog2(MDU_LATENCY);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;

   // Stall request: a new op stalls in its first cycle; once BUSY, stall
   // until the counter has drained. The release cycle (BUSY, cnt == 0)
   // deliberately ignores mdu_op_e so the departing op cannot retrigger.
   // Both outputs are forced low while reset is held.
   always_comb begin
      mdu_stall = 1'b0;
      if (reset) begin
         if (state == IDLE) begin
            mdu_stall = mdu_op_e;
         end else begin
            mdu_stall = (cnt != '0);
         end
      end
      mdu_busy = reset && (state == BUSY);
   end

   // State and counter; reset abandons any op in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mdu_op_e) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(MDU_LATENCY - 2);
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for the 5-stage RV32 core: Execute-stage forwarding selects,
// load-use stall, taken-branch flush and MDU hold sequencing.
// Ports:
//   clk, reset                  : clock, synchronous active-low reset
//   rs1_d, rs2_d                : sources of the Decode instruction
//   rs1_e, rs2_e, rd_e          : sources/destination in Execute
//   rd_m, rd_w                  : destinations in Memory / Writeback
//   reg_write_m, reg_write_w    : register-write enables in M / W
//   load_e                      : Execute instruction is a load
//   pc_src_e                    : branch/jump taken in Execute
//   mdu_op_e                    : valid MDU instruction in Execute
//   forward_a_e, forward_b_e    : forwarding mux3 selects (00 RF, 01 WB, 10 MEM)
//   stall_f, stall_d, stall_e   : hold PC, IF/ID, ID/EX
//   flush_d, flush_e, flush_m   : bubble IF/ID, ID/EX, EX/MEM
//   mdu_busy                    : MDU sequencer in BUSY
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LATENCY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic [4:0] rs1_e,
   input  logic [4:0] rs2_e,
   input  logic [4:0] rd_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   input  logic       load_e,
   input  logic       pc_src_e,
   input  logic       mdu_op_e,
   output logic [1:0] forward_a_e,
   output logic [1:0] forward_b_e,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_m,
   output logic       mdu_busy
);

   logic lw_stall;
   logic mdu_stall;

   mdu_stall_fsm #(
      .MDU_LATENCY(MDU_LATENCY)
   ) u_mdu_fsm (
      .clk      (clk),
      .reset    (reset),
      .mdu_op_e (mdu_op_e),
      .mdu_stall(mdu_stall),
      .mdu_busy (mdu_busy)
   );

   // Load-use: the Decode instruction needs a value the Execute load has
   // not fetched yet, so hold it one cycle and bubble Execute.
   always_comb begin
      lw_stall = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   end

   // Output equations. A held Execute instruction is never flushed, so the
   // branch/load-use flushes are masked by the MDU stall. While reset is held
   // the pipe is flushed and nothing is stalled or forwarded.
   always_comb begin
      forward_a_e = FWD_RF;
      forward_b_e = FWD_RF;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m     = 1'b1;
      if (reset) begin
         forward_a_e = fwd_select(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w);
         forward_b_e = fwd_select(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w);
         stall_f     = lw_stall || mdu_stall;
         stall_d     = lw_stall || mdu_stall;
         stall_e     = mdu_stall;
         flush_m     = mdu_stall;
         flush_d     = pc_src_e && !mdu_stall;
         flush_e     = (lw_stall || pc_src_e) && !mdu_stall;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share all inputs: dut4 with
// MDU_LATENCY = 4 and dut2 with MDU_LATENCY = 2. Inputs change just after a
// falling edge; outputs are sampled 1 ns later, well away from the rising edge.
// Status vectors are {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
// mdu_busy}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       reg_write_m, reg_write_w, load_e, pc_src_e, mdu_op_e;

   logic [1:0] fa4, fb4, fa2, fb2;
   logic       sf4, sd4, se4, fd4, fe4, fm4, busy4;
   logic       sf2, sd2, se2, fd2, fe2, fm2, busy2;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.MDU_LATENCY(4)) dut4 (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .load_e(load_e), .pc_src_e(pc_src_e), .mdu_op_e(mdu_op_e),
      .forward_a_e(fa4), .forward_b_e(fb4),
      .stall_f(sf4), .stall_d(sd4), .stall_e(se4),
      .flush_d(fd4), .flush_e(fe4), .flush_m(fm4), .mdu_busy(busy4)
   );

   hazard_ctrl #(.MDU_LATENCY(2)) dut2 (
      .clk(clk), .reset(reset),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .load_e(load_e), .pc_src_e(pc_src_e), .mdu_op_e(mdu_op_e),
      .forward_a_e(fa2), .forward_b_e(fb2),
      .stall_f(sf2), .stall_d(sd2), .stall_e(se2),
      .flush_d(fd2), .flush_e(fe2), .flush_m(fm2), .mdu_busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive every DUT input, then let the combinational outputs settle.
   task automatic applyStimulus(
      input logic [4:0] s1d, input logic [4:0] s2d,
      input logic [4:0] s1e, input logic [4:0] s2e, input logic [4:0] de,
      input logic [4:0] dm, input logic [4:0] dw,
      input logic wm, input logic ww, input logic ld, input logic pc, input logic mdu
   );
      rs1_d = s1d; rs2_d = s2d; rs1_e = s1e; rs2_e = s2e; rd_e = de;
      rd_m = dm; rd_w = dw; reg_write_m = wm; reg_write_w = ww;
      load_e = ld; pc_src_e = pc; mdu_op_e = mdu;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] status4();
      return {sf4, sd4, se4, fd4, fe4, fm4, busy4};
   endfunction

   function automatic logic [6:0] status2();
      return {sf2, sd2, se2, fd2, fe2, fm2, busy2};
   endfunction

   initial begin
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset held: outputs forced even with forwarding and MDU requests present.
      @(negedge clk);
      applyStimulus(0, 0, 5, 5, 0, 5, 5, 1, 1, 0, 0, 1);
      checkOutput("reset_status4", status4(), 7'b0001110);
      checkOutput("reset_status2", status2(), 7'b0001110);
      checkOutput("reset_fwd_a", {5'd0, fa4}, 7'd0);
      checkOutput("reset_fwd_b", {5'd0, fb4}, 7'd0);

      @(negedge clk);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("idle_status", status4(), 7'b0000000);

      // Forwarding priority on operand A, then operand B.
      @(negedge clk);
      applyStimulus(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0);
      checkOutput("fwd_a_mem_prio", {5'd0, fa4}, 7'd2);
      applyStimulus(0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0);
      checkOutput("fwd_a_wb", {5'd0, fa4}, 7'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      checkOutput("fwd_a_x0", {5'd0, fa4}, 7'd0);
      applyStimulus(0, 0, 0, 9, 0, 3, 9, 1, 1, 0, 0, 0);
      checkOutput("fwd_b_wb", {5'd0, fb4}, 7'd1);
      applyStimulus(0, 0, 0, 9, 0, 9, 9, 1, 0, 0, 0, 0);
      checkOutput("fwd_b_mem", {5'd0, fb4}, 7'd2);
      applyStimulus(0, 0, 0, 6, 0, 9, 9, 1, 1, 0, 0, 0);
      checkOutput("fwd_b_nomatch", {5'd0, fb4}, 7'd0);

      // Load-use, x0 destination, branch alone, branch plus load-use.
      @(negedge clk);
      applyStimulus(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("lw_rs2", status4(), 7'b1100100);
      applyStimulus(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("lw_rs1", status4(), 7'b1100100);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("lw_rd_x0", status4(), 7'b0000000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("branch_only", status4(), 7'b0001100);
      applyStimulus(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("branch_and_lw", status4(), 7'b1101100);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("lw_one_cycle", status4(), 7'b0000000);

      // MDU op held high: three stall cycles, one release, then a fresh op.
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("mdu_c1", status4(), 7'b1110010);
      @(negedge clk); #1;
      checkOutput("mdu_c2", status4(), 7'b1110011);
      @(negedge clk); #1;
      checkOutput("mdu_c3", status4(), 7'b1110011);
      @(negedge clk); #1;
      checkOutput("mdu_release", status4(), 7'b0000001);
      @(negedge clk); #1;
      checkOutput("mdu_no_retrigger", status4(), 7'b1110010);

      // Overlap with the second op: load-use and branch during the hold.
      @(negedge clk);
      applyStimulus(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("overlap_lw_pc", status4(), 7'b1110011);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("overlap_hold", status4(), 7'b1110011);
      @(negedge clk);
      applyStimulus(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("lw_after_release", status4(), 7'b1100101);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("overlap_done", status4(), 7'b0000000);

      // Reset in the second BUSY cycle abandons the op.
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("rst_op_c1", status4(), 7'b1110010);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_op_c2", status4(), 7'b1110011);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst_mid_op4", status4(), 7'b0001110);
      checkOutput("rst_mid_op2", status2(), 7'b0001110);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst_to_idle4", status4(), 7'b0000000);
      checkOutput("rst_to_idle2", status2(), 7'b0000000);

      // Fresh op after reset, both latencies.
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("fresh4_c1", status4(), 7'b1110010);
      checkOutput("lat2_c1", status2(), 7'b1110010);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("fresh4_c2", status4(), 7'b1110011);
      checkOutput("lat2_release", status2(), 7'b0000001);
      @(negedge clk); #1;
      checkOutput("fresh4_c3", status4(), 7'b1110011);
      checkOutput("lat2_idle", status2(), 7'b0000000);
      @(negedge clk); #1;
      checkOutput("fresh4_release", status4(), 7'b0000001);
      @(negedge clk); #1;
      checkOutput("fresh4_idle", status4(), 7'b0000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
